// File: rtl/qoi_pkg.sv
// Shared constants and helpers for the QOI chunk encoders.
package qoi_pkg;

  localparam logic [1:0] QOI_OP_RUN     = 2'b11;
  localparam int         QOI_MAX_RUN    = 62;
  localparam logic [7:0] QOI_INIT_ALPHA = 8'hFF;

  // Pixel every QOI image is implicitly preceded by, right-aligned in 32 bits.
  function automatic logic [31:0] qoi_init_pixel(int components);
    return (components == 4) ? {24'h0, QOI_INIT_ALPHA} : 32'h0;
  endfunction

endpackage

// File: rtl/qoi_op_run_encoder.sv
// QOI_OP_RUN stage: collapses repeated pixels into run bytes and forwards
// every non-repeating pixel with its predecessor to the following stages.
module qoi_op_run_encoder
  import qoi_pkg::*;
#(
  parameter int COMPONENTS = 4,
  parameter int MAX_RUN    = QOI_MAX_RUN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*COMPONENTS-1:0] pixel,
  input  logic                    pixel_valid,
  input  logic                    sof,
  input  logic                    eof,
  output logic [7:0]              run_byte,
  output logic                    run_valid,
  output logic [8*COMPONENTS-1:0] pix_out,
  output logic [8*COMPONENTS-1:0] prev_out,
  output logic                    pix_valid,
  output logic                    pix_last
);

  localparam int             W         = 8 * COMPONENTS;
  localparam logic [W-1:0]   INIT_PIX  = W'(qoi_init_pixel(COMPONENTS));
  localparam logic [5:0]     MAX_RUN_C = 6'(MAX_RUN);

  // Handshake: run_valid and pix_valid are single-cycle pulses with no
  // backpressure; when both fire together the run byte is ordered first.

  logic [W-1:0] prev_q, prev_d;
  logic [5:0]   run_cnt_q, run_cnt_d;
  logic [7:0]   run_byte_q, run_byte_d;
  logic         run_valid_q, run_valid_d;
  logic [W-1:0] pix_out_q, pix_out_d;
  logic [W-1:0] prev_out_q, prev_out_d;
  logic         pix_valid_q, pix_valid_d;
  logic         pix_last_q, pix_last_d;

  logic [W-1:0] eff_prev;
  logic [5:0]   run_base;
  logic [5:0]   run_next;
  logic         same;

  always_comb begin
    // A new image starts from the implicit initial pixel with no pending run.
    eff_prev = sof ? INIT_PIX : prev_q;
    run_base = sof ? 6'd0 : run_cnt_q;
    run_next = run_base + 6'd1;
    same     = (pixel == eff_prev);

    prev_d      = prev_q;
    run_cnt_d   = run_cnt_q;
    run_byte_d  = run_byte_q;
    run_valid_d = 1'b0;
    pix_out_d   = pix_out_q;
    prev_out_d  = prev_out_q;
    pix_valid_d = 1'b0;
    pix_last_d  = 1'b0;

    if (pixel_valid) begin
      prev_d = pixel;
      if (same) begin
        if (run_next == MAX_RUN_C || eof) begin
          run_byte_d  = {QOI_OP_RUN, run_next - 6'd1};
          run_valid_d = 1'b1;
          run_cnt_d   = 6'd0;
        end else begin
          run_cnt_d = run_next;
        end
      end else begin
        if (run_base != 6'd0) begin
          run_byte_d  = {QOI_OP_RUN, run_base - 6'd1};
          run_valid_d = 1'b1;
        end
        pix_out_d   = pixel;
        prev_out_d  = eff_prev;
        pix_valid_d = 1'b1;
        pix_last_d  = eof;
        run_cnt_d   = 6'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= INIT_PIX;
      run_cnt_q   <= 6'd0;
      run_byte_q  <= 8'd0;
      run_valid_q <= 1'b0;
      pix_out_q   <= '0;
      prev_out_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      run_cnt_q   <= run_cnt_d;
      run_byte_q  <= run_byte_d;
      run_valid_q <= run_valid_d;
      pix_out_q   <= pix_out_d;
      prev_out_q  <= prev_out_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign run_byte  = run_byte_q;
  assign run_valid = run_valid_q;
  assign pix_out   = pix_out_q;
  assign prev_out  = prev_out_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;

endmodule

// File: doc/qoi_op_run_encoder.md
Name: qoi_op_run_encoder

Overview:
First stage of the QOI encode pipeline. It sits directly upstream of the QOI_OP_INDEX encoder.
- Compares each incoming pixel with the previous pixel.
- Collapses repeats into QOI_OP_RUN bytes (0b11, then a 6-bit run-minus-one field).
- Forwards every non-repeating pixel downstream, together with its predecessor, for the index/diff/luma stages.
- Streaming, no backpressure, 1-cycle registered latency.

Parameters:
- COMPONENTS, 4, number of 8-bit components per pixel (3 = RGB, 4 = RGBA).
- MAX_RUN, 62, longest run encodable in one QOI_OP_RUN byte. Fixed by the format; must not exceed 62.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pixel  input  8*COMPONENTS  input pixel; R in the MSBs, then G, B, (A).
- pixel_valid  input  1  pixel qualifier, active high.
- sof  input  1  first pixel of image; meaningful only with pixel_valid.
- eof  input  1  last pixel of image; meaningful only with pixel_valid.
- run_byte  output  8  QOI_OP_RUN byte.
- run_valid  output  1  run_byte valid for this cycle.
- pix_out  output  8*COMPONENTS  forwarded non-repeating pixel.
- prev_out  output  8*COMPONENTS  pixel that preceded pix_out in the stream.
- pix_valid  output  1  pix_out and prev_out valid.
- pix_last  output  1  pix_out is the last pixel of the image.

Behaviour:
- Reset (async assert, sync release):
  - run_byte=0, run_valid=0, pix_out=0, prev_out=0, pix_valid=0, pix_last=0.
  - run_cnt=0.
  - prev = initial pixel: R=G=B=0, A=8'hFF when COMPONENTS=4.
  - A reset mid-run discards the pending run; no byte is emitted.
- Internal state: prev register (8*COMPONENTS bits) and run_cnt (6 bits, range 0..MAX_RUN).
- Effective previous pixel: the initial pixel when sof=1, otherwise the prev register. On sof, any pending run_cnt is discarded and the count restarts from 0.
- Equality: full-width compare across all COMPONENTS. COMPONENTS=3 therefore never compares alpha.
- All outputs are registered. The response to the pixel accepted in cycle N appears in cycle N+1. Every valid output is a single-cycle pulse.
- pixel_valid=0: no state change; run_valid=0, pix_valid=0, pix_last=0 next cycle.
- pixel_valid=1 and pixel == effective prev:
  - n = run_cnt + 1.
  - If n == MAX_RUN or eof=1: run_byte = 8'hC0 | (n-1), run_valid=1, run_cnt=0.
  - Otherwise: run_cnt=n, no output.
- pixel_valid=1 and pixel != effective prev:
  - If run_cnt > 0: run_byte = 8'hC0 | (run_cnt-1), run_valid=1.
  - In the same cycle: pix_out=pixel, prev_out=effective prev, pix_valid=1, pix_last=eof, run_cnt=0.
  - When run_valid and pix_valid are both asserted, the run byte precedes the pixel's chunk in the stream. The downstream merger serializes them in that order.
- prev is updated to pixel on every valid pixel.
- Wrap: a run of 62 emits 0xFD; the 63rd identical pixel starts a new count at 1.
- Simultaneous sof and eof (1-pixel image): treated as a pixel compared against the initial pixel, with flush.
- Output data registers hold their last values when the valid signals are low.

Decomposition:
- qoi_pkg holds: QOI_OP_RUN tag 2'b11, QOI_MAX_RUN=62, QOI_INIT_ALPHA=8'hFF, and an initial-pixel function parameterised by COMPONENTS. The other chunk encoders share these.
- No sub-module: comparator, counter and output registers are a single always_ff plus compare logic.

Test Plan:
1. Reset; valid 32'h000000FF, then 32'h11223344 (COMPONENTS=4) → cycle 1 nothing. Next cycle: run_byte=8'hC0, run_valid=1, pix_valid=1, pix_out=32'h11223344, prev_out=32'h000000FF.
2. 62 consecutive 32'hAABBCCDD after a distinct pixel → single run_valid with 8'hFD one cycle after the 62nd; a 63rd identical pixel followed by a different pixel → 8'hC0 plus pix_valid.
3. 5 identical pixels, then a 6th identical with eof=1 → run_byte=8'hC5, run_valid=1, pix_valid=0.
4. Different pixel with eof=1 and run_cnt=3 → same cycle run_byte=8'hC2, run_valid=1, pix_valid=1, pix_last=1.
5. Run in progress (run_cnt=10), assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately. After release, pixel 32'h000000FF then a different pixel → run_byte=8'hC0 (count restarted).
6. COMPONENTS=3: sof with 24'h000000 → counted as a run (no pix_valid). Idle cycles with pixel_valid=0 between pixels → run_cnt unchanged, no outputs.
